// File: rtl/id_ex_hazard_stage_if.sv
// Decode-to-execute bundle for the ID/EX register.
// Decode drives the *_D side; the stage drives the *_E side.
interface id_ex_hazard_stage_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] RD1_D;
    logic [XLEN-1:0] RD2_D;
    logic [XLEN-1:0] Imm_Ext_D;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic [4:0]      RS1_D;
    logic [4:0]      RS2_D;
    logic [4:0]      RD_D;
    logic            RegWriteD;
    logic [1:0]      ResultSrcD;
    logic            MemWriteD;
    logic            ALUSrcD;
    logic            BranchD;
    logic            JumpD;
    logic [2:0]      ALUControlD;

    logic [XLEN-1:0] RD1_E;
    logic [XLEN-1:0] RD2_E;
    logic [XLEN-1:0] Imm_Ext_E;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;
    logic [4:0]      RS1_E;
    logic [4:0]      RS2_E;
    logic [4:0]      RD_E;
    logic            RegWriteE;
    logic [1:0]      ResultSrcE;
    logic            MemWriteE;
    logic            ALUSrcE;
    logic            BranchE;
    logic            JumpE;
    logic [2:0]      ALUControlE;
    logic            ValidE;

    modport master (
        output RD1_D, RD2_D, Imm_Ext_D, PCD, PCPlus4D,
        output RS1_D, RS2_D, RD_D,
        output RegWriteD, ResultSrcD, MemWriteD,
        output ALUSrcD, BranchD, JumpD, ALUControlD,
        input  RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E,
        input  RS1_E, RS2_E, RD_E,
        input  RegWriteE, ResultSrcE, MemWriteE,
        input  ALUSrcE, BranchE, JumpE, ALUControlE,
        input  ValidE
    );

    modport slave (
        input  RD1_D, RD2_D, Imm_Ext_D, PCD, PCPlus4D,
        input  RS1_D, RS2_D, RD_D,
        input  RegWriteD, ResultSrcD, MemWriteD,
        input  ALUSrcD, BranchD, JumpD, ALUControlD,
        output RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E,
        output RS1_E, RS2_E, RD_E,
        output RegWriteE, ResultSrcE, MemWriteE,
        output ALUSrcE, BranchE, JumpE, ALUControlE,
        output ValidE
    );
endinterface

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use stall and
// control-flush generation plus bubble/flush counters.
module id_ex_hazard_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    id_ex_hazard_stage_if.slave  bus,
    input  logic                 PCSrcE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic [CNT_W-1:0]     BubbleCount,
    output logic [CNT_W-1:0]     FlushCount
);

    typedef struct packed {
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_write;
        logic [1:0]      result_src;
        logic            mem_write;
        logic            alu_src;
        logic            branch;
        logic            jump;
        logic [2:0]      alu_ctrl;
        logic            valid;
    } ex_t;

    ex_t  d_in;
    ex_t  e_q;
    logic lw_stall;

    assign d_in = {
        bus.RD1_D, bus.RD2_D, bus.Imm_Ext_D,
        bus.PCD, bus.PCPlus4D,
        bus.RS1_D, bus.RS2_D, bus.RD_D,
        bus.RegWriteD, bus.ResultSrcD,
        bus.MemWriteD, bus.ALUSrcD,
        bus.BranchD, bus.JumpD,
        bus.ALUControlD, 1'b1
    };

    // Load-use detect; a taken branch/jump overrides the stall.
    always_comb begin
        lw_stall = e_q.valid
                 && (e_q.result_src == 2'b01)
                 && (e_q.rd != 5'd0)
                 && ((e_q.rd == bus.RS1_D)
                  || (e_q.rd == bus.RS2_D));
        StallF = lw_stall & ~PCSrcE;
        StallD = lw_stall & ~PCSrcE;
        FlushD = PCSrcE;
        FlushE = lw_stall | PCSrcE;
    end

    // D->E register; a bubble zeroes every field, indices included.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_q <= '0;
        end else if (FlushE) begin
            e_q <= '0;
        end else begin
            e_q <= d_in;
        end
    end

    assign bus.RD1_E       = e_q.rd1;
    assign bus.RD2_E       = e_q.rd2;
    assign bus.Imm_Ext_E   = e_q.imm;
    assign bus.PCE         = e_q.pc;
    assign bus.PCPlus4E    = e_q.pc4;
    assign bus.RS1_E       = e_q.rs1;
    assign bus.RS2_E       = e_q.rs2;
    assign bus.RD_E        = e_q.rd;
    assign bus.RegWriteE   = e_q.reg_write;
    assign bus.ResultSrcE  = e_q.result_src;
    assign bus.MemWriteE   = e_q.mem_write;
    assign bus.ALUSrcE     = e_q.alu_src;
    assign bus.BranchE     = e_q.branch;
    assign bus.JumpE       = e_q.jump;
    assign bus.ALUControlE = e_q.alu_ctrl;
    assign bus.ValidE      = e_q.valid;

    // Saturating counters; a flush bubble is never counted as load-use.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            BubbleCount <= '0;
            FlushCount  <= '0;
        end else begin
            if (lw_stall && !PCSrcE && !(&BubbleCount))
                BubbleCount <= BubbleCount + CNT_W'(1);
            if (PCSrcE && !(&FlushCount))
                FlushCount <= FlushCount + CNT_W'(1);
        end
    end

endmodule

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
- ID/EX pipeline register for the 5-stage pipelined RISC-V core, combined with load-use hazard detection and control-hazard flush generation.
- Captures decoded operands and control each cycle and presents them to the execute stage.
- Its RS1_E/RS2_E/RD_E/RegWriteE outputs feed the execute-stage forwarding logic.
- Produces StallF/StallD/FlushD/FlushE for the fetch and decode registers, and keeps bubble/flush performance counters.

Parameters:
XLEN, 32, datapath width of operands, immediate and PC fields
CNT_W, 32, width of performance counters

Ports:
clk  in  1  core clock, all state rises on posedge
rst  in  1  asynchronous active-low reset
RD1_D  in  XLEN  rs1 register-file read data from decode
RD2_D  in  XLEN  rs2 register-file read data from decode
Imm_Ext_D  in  XLEN  sign-extended immediate
PCD  in  XLEN  decode-stage PC
PCPlus4D  in  XLEN  decode-stage PC+4
RS1_D  in  5  rs1 index in decode
RS2_D  in  5  rs2 index in decode
RD_D  in  5  rd index in decode
RegWriteD  in  1  instruction writes rd
ResultSrcD  in  2  00 ALU, 01 load data, 10 PC+4
MemWriteD  in  1  store
ALUSrcD  in  1  ALU B source is immediate
BranchD  in  1  conditional branch
JumpD  in  1  jal/jalr
ALUControlD  in  3  ALU operation
PCSrcE  in  1  branch/jump taken, resolved in execute
RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  out  XLEN  registered copies
RS1_E, RS2_E, RD_E  out  5  registered indices
RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE  out  1  registered control
ResultSrcE  out  2  registered result select
ALUControlE  out  3  registered ALU op
ValidE  out  1  execute slot holds a real instruction
StallF  out  1  hold PC register
StallD  out  1  hold IF/ID register
FlushD  out  1  clear IF/ID register
FlushE  out  1  internal bubble request, exported for debug
BubbleCount  out  CNT_W  load-use bubbles inserted
FlushCount  out  CNT_W  control-flush bubbles inserted

Behaviour:
- Reset (rst=0, async): every registered output and both counters clear to 0; ValidE=0.
- Load-use detect (combinational): lwStall = (ResultSrcE==2'b01) & ValidE & (RD_E!=0) & ((RD_E==RS1_D) | (RD_E==RS2_D)).
- StallF = StallD = lwStall & ~PCSrcE.
- FlushD = PCSrcE.
- FlushE = lwStall | PCSrcE.
- Each posedge, normal case: all *_D fields load into *_E; ValidE <= 1.
- Each posedge, when FlushE=1 (bubble): all E outputs load 0, including RS1_E/RS2_E/RD_E and data fields; ValidE <= 0.
  - Zeroed indices guarantee no false forwarding match.
- Latency: one cycle D->E. No hold mode; this register never stalls, it only bubbles.
- Simultaneous lwStall and PCSrcE (not reachable with a legal decoder, but defined):
  - Flush wins; StallF/StallD deasserted.
  - Single bubble inserted, counted in FlushCount only.
- Counters:
  - BubbleCount += 1 on each posedge with lwStall & ~PCSrcE.
  - FlushCount += 1 on each posedge with PCSrcE.
  - Both saturate at all-ones; no wrap.
- rd=x0 load never stalls. A bubble in E (ValidE=0) never causes a stall.
- Reset asserted mid-stall: outputs clear immediately; the stall releases combinationally because ValidE=0.

Test Plan:
- Reset: drive nonzero D inputs and hold rst=0 -> all E outputs 0, ValidE=0, counters 0; release rst -> next edge E mirrors D, ValidE=1.
- Load-use on rs1: E holds lw x5 (ResultSrcE=01, RD_E=5), D has RS1_D=5 -> StallF=StallD=1, FlushE=1. Next edge: RegWriteE=0, RD_E=0, ValidE=0, BubbleCount=1. Following edge: D instruction enters E.
- No stall cases: load with RD_E=0 vs RS2_D=0 -> StallF=0. ALU op (ResultSrcE=00) with RD_E=RS1_D=7 -> no stall.
- Taken branch: PCSrcE=1 -> FlushD=1, FlushE=1, StallF=0. Next edge: E zeroed, FlushCount=1.
- Simultaneous: lwStall condition and PCSrcE=1 forced together -> StallD=0, FlushD=1, one bubble, FlushCount+1, BubbleCount unchanged.
- Saturation: preload BubbleCount to 32'hFFFF_FFFF, trigger load-use -> value stays 32'hFFFF_FFFF.
